// File: rtl/neo_ligth_pkg.sv
// neo_ligth_pkg: shared encodings, state types and helpers for the UART command front end
package neo_ligth_pkg;
  localparam logic [1:0] ACC_STOP  = 2'b00;
  localparam logic [1:0] ACC_OPEN  = 2'b01;
  localparam logic [1:0] ACC_CLOSE = 2'b10;
  localparam logic [7:0] HDR_BYTE  = 8'hA5;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_HUNT, P_OP, P_DHI, P_DLO, P_CHK} parse_state_t;
  function automatic logic [15:0] clamp_duty(input logic [15:0] d, input logic [15:0] mx);
    return (d > mx) ? mx : d;
  endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver with 2-flop input synchronizer and start-glitch rejection
module uart_rx_byte
  import neo_ligth_pkg::*;
#(
  parameter int DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       rx_busy
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
  logic [1:0]    r_sync;
  logic          r_prev;
  rx_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          w_rx;
  logic          w_stop;
  assign w_rx       = r_sync[1];
  assign w_stop     = (r_state == RX_STOP) && (r_cnt == LAST);
  assign byte_valid = w_stop && w_rx;
  assign frame_err  = w_stop && !w_rx;
  assign byte_data  = r_shift;
  assign rx_busy    = r_state != RX_IDLE;
  // Synchronize rx, then walk start/data/stop sampling at bit centres
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_prev  <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_sync <= {r_sync[0], rx};
      r_prev <= w_rx;
      r_cnt  <= r_cnt + CW'(1);
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          if (r_prev && !w_rx) r_state <= RX_START;
        end
        RX_START: if (r_cnt == HALF_M1) begin
          r_cnt   <= '0;
          r_bit   <= '0;
          r_state <= w_rx ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (r_cnt == LAST) begin
          r_cnt   <= '0;
          r_shift <= {w_rx, r_shift[7:1]};
          r_bit   <= r_bit + 3'd1;
          if (r_bit == 3'd7) r_state <= RX_STOP;
        end
        RX_STOP: if (r_cnt == LAST) begin
          r_cnt   <= '0;
          r_state <= RX_IDLE;
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: assembles 5-byte A5-headed command frames, validates them and holds the last good command
module uart_cmd_decoder
  import neo_ligth_pkg::*;
#(
  parameter int          CLK_HZ      = 50_000_000,
  parameter int          BAUD        = 9600,
  parameter int          TIMEOUT_CYC = 208_320,
  parameter logic [15:0] DUTY_MAX    = 16'd50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [1:0]  cmd_accion,
  output logic [15:0] cmd_dutty,
  output logic        cmd_valid,
  output logic        cmd_err,
  output logic        busy
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  logic         w_byte_valid;
  logic [7:0]   w_byte_data;
  logic         w_frame_err;
  logic         w_rx_busy;
  logic         w_op_ok;
  logic         w_chk_ok;
  logic         w_timeout;
  parse_state_t r_pstate;
  logic [7:0]   r_op;
  logic [7:0]   r_dhi;
  logic [7:0]   r_dlo;
  logic [TW-1:0] r_to;
  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_valid(w_byte_valid),
    .byte_data (w_byte_data),
    .frame_err (w_frame_err),
    .rx_busy   (w_rx_busy)
  );
  assign w_op_ok   = (r_op[7:2] == 6'd0) &&
                     (r_op[1:0] == ACC_STOP || r_op[1:0] == ACC_OPEN || r_op[1:0] == ACC_CLOSE);
  assign w_chk_ok  = w_byte_data == (r_op ^ r_dhi ^ r_dlo);
  assign w_timeout = (r_pstate != P_HUNT) && (r_to == TW'(TIMEOUT_CYC - 1));
  assign busy      = w_rx_busy || (r_pstate != P_HUNT);
  // Inter-byte idle counter; a received byte always clears it, even on the expiry cycle
  always_ff @(posedge clk) begin
    if (rst) r_to <= '0;
    else     r_to <= (w_byte_valid || r_pstate == P_HUNT) ? '0 : r_to + TW'(1);
  end
  // Frame parser with registered command outputs and one-cycle valid/error strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pstate   <= P_HUNT;
      r_op       <= '0;
      r_dhi      <= '0;
      r_dlo      <= '0;
      cmd_accion <= ACC_STOP;
      cmd_dutty  <= '0;
      cmd_valid  <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
      if (w_byte_valid) begin
        case (r_pstate)
          P_HUNT: if (w_byte_data == HDR_BYTE) r_pstate <= P_OP;
          P_OP: begin
            r_op     <= w_byte_data;
            r_pstate <= P_DHI;
          end
          P_DHI: begin
            r_dhi    <= w_byte_data;
            r_pstate <= P_DLO;
          end
          P_DLO: begin
            r_dlo    <= w_byte_data;
            r_pstate <= P_CHK;
          end
          P_CHK: begin
            r_pstate <= P_HUNT;
            if (w_chk_ok && w_op_ok) begin
              cmd_accion <= r_op[1:0];
              cmd_dutty  <= clamp_duty({r_dhi, r_dlo}, DUTY_MAX);
              cmd_valid  <= 1'b1;
            end else begin
              cmd_err <= 1'b1;
            end
          end
          default: r_pstate <= P_HUNT;
        endcase
      end else if ((w_frame_err && r_pstate != P_HUNT) || w_timeout) begin
        cmd_err  <= 1'b1;
        r_pstate <= P_HUNT;
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: scoreboard bench driving serial frames and checking strobes and held command values
module tb_uart_cmd_decoder;
  localparam int          CLK_HZ = 1_000_000;
  localparam int          BAUD   = 100_000;
  localparam int          DIV    = CLK_HZ / BAUD;
  localparam int          TO     = 400;
  localparam logic [15:0] DMAX   = 16'd50_000;
  // raw rx edge -> two sync flops -> edge register, then half bit plus 9 bits to the stop sample, plus output register
  localparam int          LAT    = 3 + DIV / 2 + 9 * DIV;
  typedef struct packed {
    logic        err;
    logic [1:0]  acc;
    logic [15:0] duty;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [1:0]  cmd_accion;
  logic [15:0] cmd_dutty;
  logic        cmd_valid;
  logic        cmd_err;
  logic        busy;
  int          checks = 0;
  int          failures = 0;
  logic [1:0]  m_acc = 2'b00;
  logic [15:0] m_duty = 16'd0;
  exp_t        q[$];

  uart_cmd_decoder #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_CYC(TO), .DUTY_MAX(DMAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .cmd_accion(cmd_accion),
    .cmd_dutty (cmd_dutty),
    .cmd_valid (cmd_valid),
    .cmd_err   (cmd_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (cmd_valid || cmd_err)) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe valid=%0b err=%0b acc=%0h duty=%0h", cmd_valid, cmd_err, cmd_accion, cmd_dutty);
      end else begin
        e = q.pop_front();
        if ({cmd_valid, cmd_err, cmd_accion, cmd_dutty} !== {~e.err, e.err, e.acc, e.duty}) begin
          failures++;
          $display("FAIL scoreboard got valid=%0b err=%0b acc=%0h duty=%0h want valid=%0b err=%0b acc=%0h duty=%0h",
                   cmd_valid, cmd_err, cmd_accion, cmd_dutty, ~e.err, e.err, e.acc, e.duty);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_frame(input logic [7:0] op, input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] ck);
    logic [15:0] d;
    d = {hi, lo};
    if (ck == (op ^ hi ^ lo) && op < 8'd3) begin
      m_acc  = op[1:0];
      m_duty = (d > DMAX) ? DMAX : d;
      q.push_back({1'b0, m_acc, m_duty});
    end else begin
      q.push_back({1'b1, m_acc, m_duty});
    end
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] ck);
    expect_frame(op, hi, lo, ck);
    send_byte(8'hA5);
    send_byte(op);
    send_byte(hi);
    send_byte(lo);
    send_byte(ck);
  endtask

  task automatic test_reset();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({cmd_accion, cmd_dutty, cmd_valid, cmd_err, busy} !== 21'd0) begin
      failures++;
      $display("FAIL reset_state got acc=%0h duty=%0h valid=%0b err=%0b busy=%0b want all zero",
               cmd_accion, cmd_dutty, cmd_valid, cmd_err, busy);
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    expect_frame(8'h01, 8'h12, 8'h34, 8'h27);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    fork
      send_byte(8'h27);
      begin
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0) begin
          failures++;
          $display("FAIL latency_early valid=%0b want 0", cmd_valid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_err !== 1'b0) begin
          failures++;
          $display("FAIL latency_on_time valid=%0b err=%0b want valid=1 err=0", cmd_valid, cmd_err);
        end
      end
    join
    checks++;
    if (cmd_accion !== 2'b01 || cmd_dutty !== 16'h1234) begin
      failures++;
      $display("FAIL held_first acc=%0h duty=%0h want acc=1 duty=1234", cmd_accion, cmd_dutty);
    end
  endtask

  task automatic test_clamp();
    send_frame(8'h02, 8'hFF, 8'hFF, 8'h02 ^ 8'hFF ^ 8'hFF);
    checks++;
    if (cmd_accion !== 2'b10 || cmd_dutty !== 16'd50_000) begin
      failures++;
      $display("FAIL clamp acc=%0h duty=%0d want acc=2 duty=50000", cmd_accion, cmd_dutty);
    end
    send_frame(8'h00, 8'hC3, 8'h51, 8'h00 ^ 8'hC3 ^ 8'h51);
    send_frame(8'h01, 8'hC3, 8'h4F, 8'h01 ^ 8'hC3 ^ 8'h4F);
    send_frame(8'h00, 8'hC3, 8'h50, 8'h00 ^ 8'hC3 ^ 8'h50);
  endtask

  task automatic test_rejects();
    send_frame(8'h01, 8'h12, 8'h34, 8'h00);
    send_frame(8'h02, 8'h00, 8'h10, 8'h12);
    send_frame(8'h03, 8'h00, 8'h00, 8'h03);
    send_frame(8'hFF, 8'h00, 8'h00, 8'hFF);
    send_frame(8'h01, 8'h00, 8'h20, 8'h21);
  endtask

  task automatic test_hunt_and_data_hdr();
    send_byte(8'h33);
    send_byte(8'h00);
    send_frame(8'h01, 8'hA5, 8'h00, 8'h01 ^ 8'hA5 ^ 8'h00);
    send_frame(8'hA5, 8'h00, 8'h00, 8'hA5);
    send_frame(8'h02, 8'h00, 8'h07, 8'h02 ^ 8'h00 ^ 8'h07);
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || q.size() != 0) begin
      failures++;
      $display("FAIL glitch busy=%0b pending=%0d want busy=0 pending=0", busy, q.size());
    end
  endtask

  task automatic test_timeout();
    int n;
    q.push_back({1'b1, m_acc, m_duty});
    send_byte(8'hA5);
    send_byte(8'h00);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!cmd_err && n < 600);
    checks++;
    if (n != LAT + TO - 10 * DIV) begin
      failures++;
      $display("FAIL timeout_cycle got=%0d want=%0d", n, LAT + TO - 10 * DIV);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_hunt busy=%0b want 0", busy);
    end
    repeat (100) @(posedge clk);
    #1;
    send_frame(8'h01, 8'h00, 8'h55, 8'h01 ^ 8'h00 ^ 8'h55);
  endtask

  task automatic test_stop_err();
    q.push_back({1'b1, m_acc, m_duty});
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h12, 1'b0);
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send_frame(8'h02, 8'h01, 8'h02, 8'h02 ^ 8'h01 ^ 8'h02);
  endtask

  task automatic test_reset_mid();
    send_byte(8'hA5);
    send_byte(8'h01);
    rx = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cmd_accion, cmd_dutty, cmd_valid, cmd_err, busy} !== 21'd0) begin
      failures++;
      $display("FAIL reset_mid acc=%0h duty=%0h valid=%0b err=%0b busy=%0b want all zero",
               cmd_accion, cmd_dutty, cmd_valid, cmd_err, busy);
    end
    rst = 1'b0;
    rx = 1'b1;
    m_acc = 2'b00;
    m_duty = 16'd0;
    repeat (200) @(posedge clk);
    #1;
    checks++;
    if (cmd_accion !== 2'b00 || cmd_dutty !== 16'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_after acc=%0h duty=%0h busy=%0b want 0 0 0", cmd_accion, cmd_dutty, busy);
    end
    send_frame(8'h01, 8'h00, 8'h99, 8'h01 ^ 8'h00 ^ 8'h99);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_clamp();
    test_rejects();
    test_hunt_and_data_hdr();
    test_glitch();
    test_timeout();
    test_stop_err();
    test_reset_mid();
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL missing_strobes pending=%0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
